instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Requester side of the instruction memory interface. It holds the PC and issues
//  word-aligned read requests to instruction memory with a valid/ready handshake.
//  In-order responses are buffered in a small prefetch queue and presented to
//  decode with valid/ready. Branch/jump redirects flush the queue and discard stale
//  responses still in flight.
// PARAMETERS
//  ADDR_W      32            address width; PC and request address width
//  DATA_W      32            instruction width
//  RESET_PC    32'h0000_0000 PC loaded on reset; must be 4-byte aligned
//  QDEPTH      2             prefetch queue entries (power of two, >=2); also the max in-flight requests
// PORTS
//  clk             in   1       single clock; all state updates on rising edge
//  rst             in   1       synchronous, active-high reset
//  imem_req_valid  out  1       request valid
//  imem_req_ready  in   1       memory accepts request (transfer = valid & ready)
//  imem_req_addr   out  ADDR_W  fetch address (= fetch PC)
//  imem_resp_valid in   1       response valid; in order; >=1 cycle after accept; no backpressure
//  imem_resp_data  in   DATA_W  fetched instruction
//  redirect_valid  in   1       branch/jump redirect, single-cycle pulse
//  redirect_pc     in   ADDR_W  redirect target
//  dec_valid       out  1       instruction available to decode (queue not empty)
//  dec_ready       in   1       decode accepts (transfer = valid & ready)
//  dec_instr       out  DATA_W  head-of-queue instruction
//  dec_pc          out  ADDR_W  PC of dec_instr
//  fetch_fault     out  1       misaligned redirect (IFU_MISALIGN_TRAP_EN only, else tied 0)
// BEHAVIOUR
//  Reset: fetch_pc=RESET_PC, queue empty, inflight=0, drop=0, state=IDLE.
//   imem_req_valid=0, dec_valid=0, dec_instr=0, dec_pc=0, fetch_fault=0.
//  FSM states:
//   IDLE  : one cycle after reset, no request; next FETCH.
//   FETCH : imem_req_valid = (inflight + count < QDEPTH). On accept, fetch_pc += 4
//           (mod 2^ADDR_W; wrap from 0xFFFF_FFFC to 0 is silent) and inflight++.
//   DRAIN : entered on redirect when stale in-flight responses exist. No requests
//           issued; each response decrements drop and is discarded. Returns to
//           FETCH on the cycle drop reaches 0, with request issue starting the
//           following cycle.
//  Response: if drop=0, push {data, pc} to queue (pc tracked in a parallel PC FIFO);
//   inflight--. The credit rule guarantees the queue never overflows. A response
//   arriving with a full queue is a protocol error: assert, no write.
//  Decode: dec_valid = !empty. The head is registered and stable while dec_valid &
//   !dec_ready. Push and pop in the same cycle are both allowed at full or empty.
//   Minimum latency is 2 cycles (request accept -> resp -> dec_valid next cycle).
//  Redirect (highest priority):
//   - fetch_pc <= redirect_pc; queue flushed; drop <= inflight plus any request
//     accepted this cycle, minus any response arriving this cycle.
//   - Next state is DRAIN if the new drop > 0, else FETCH.
//   - A response arriving in the redirect cycle is discarded.
//   - A dec transfer in the same cycle completes (that instruction is consumed).
//   - A redirect while in DRAIN accumulates correctly; nothing from the old path is
//     ever delivered.
//  Reset mid-operation: all state returns to reset values next edge. Stale memory
//   responses after reset are the memory's responsibility (memory also resets).
// CONFIGURATION
//  IFU_MISALIGN_TRAP_EN defined:
//   - A redirect with redirect_pc[1:0]!=0 sets fetch_fault=1 and enters HALT.
//   - HALT issues no requests; queue is flushed and drop is counted as usual.
//   - Only rst or an aligned redirect clears fetch_fault and leaves HALT.
//  Not defined:
//   - redirect_pc[1:0] is forced to 2'b00; fetch_fault is tied 0; no HALT state.
// TESTING
//  1 Reset, mem 1-cycle latency, dec_ready=1 -> requests at 0,4,8,...; first
//    dec_valid with dec_pc=0 two cycles after first accept; one instr/cycle steady.
//  2 dec_ready=0 for 10 cycles -> exactly QDEPTH requests issued, then
//    imem_req_valid=0; dec_instr/dec_pc held stable; resume -> order 0,4 kept.
//  3 Redirect to 0x100 with 2 in flight (mem latency 3) -> both responses dropped,
//    no requests until drained; next dec_pc=0x100, then 0x104.
//  4 Redirect same cycle as resp_valid and dec transfer -> transferred instr
//    consumed once; response discarded; queue empty next cycle.
//  5 Random imem_req_ready/latency 1-4, dec_ready random, 1000 instrs ->
//    dec_pc strictly +4 between redirects; no overflow assert.
//  6 IFU_MISALIGN_TRAP_EN: redirect to 0x102 -> fetch_fault=1, no requests;
//    aligned redirect to 0x200 -> fault clears, fetch resumes at 0x200.
//    Without macro: same stimulus -> fetch at 0x100.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC, instruction memory requests and prefetch queue toward decode
// Optional feature macro: IFU_MISALIGN_TRAP_EN (misaligned redirect raises fetch_fault and halts fetch)
module instruction_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int                QDEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [DATA_W-1:0] imem_resp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [DATA_W-1:0] dec_instr,
  output logic [ADDR_W-1:0] dec_pc,
  output logic              fetch_fault
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt;
  logic [ADDR_W-1:0] resp_pc;
  logic [ADDR_W-1:0] redir_target;
  logic [CW-1:0]     inflight, inflight_nxt;
  logic [CW-1:0]     drop, drop_nxt;
  logic [CW-1:0]     count, count_nxt;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [DATA_W-1:0] instr_mem [QDEPTH];
  logic [ADDR_W-1:0] pc_mem    [QDEPTH];
  logic              req_fire, dec_fire, resp_live, q_full, q_write, q_pop;

`ifdef IFU_MISALIGN_TRAP_EN
  logic              fault_q, fault_nxt;
`endif

  // Responses are in order, so while drop is nonzero every response belongs to an abandoned path
  assign req_fire     = imem_req_valid & imem_req_ready;
  assign dec_fire     = dec_valid & dec_ready;
  assign resp_live    = imem_resp_valid & (drop == '0);
  assign q_full       = (count == CW'(QDEPTH));
  assign q_pop        = dec_fire;
  assign q_write      = resp_live & ~redirect_valid & (~q_full | q_pop);
  assign redir_target = redirect_pc & ~ADDR_W'(3);

  // A request is only issued when its response is guaranteed a queue slot
  assign imem_req_valid = (state == FETCH) && ((inflight + count) < CW'(QDEPTH));
  assign imem_req_addr  = fetch_pc;
  assign dec_valid      = (count != '0);
  assign dec_instr      = dec_valid ? instr_mem[rd_ptr] : '0;
  assign dec_pc         = dec_valid ? pc_mem[rd_ptr] : '0;

  // Credit and drop bookkeeping; a redirect turns everything outstanding into drop
  always_comb begin
    inflight_nxt = inflight;
    drop_nxt     = drop;
    count_nxt    = count;
    if (redirect_valid) begin
      inflight_nxt = '0;
      drop_nxt     = drop + inflight + CW'(req_fire) - CW'(imem_resp_valid);
      count_nxt    = '0;
    end else begin
      inflight_nxt = inflight + CW'(req_fire) - CW'(resp_live);
      drop_nxt     = drop - CW'(imem_resp_valid & ~resp_live);
      count_nxt    = count + CW'(q_write) - CW'(q_pop);
    end
  end

  // Next state and next fetch PC; redirect overrides normal sequencing
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
`ifdef IFU_MISALIGN_TRAP_EN
    fault_nxt    = fault_q;
`endif
    case (state)
      IDLE:    state_nxt = FETCH;
      DRAIN:   if (drop_nxt == '0) state_nxt = FETCH;
      default: state_nxt = state;
    endcase
    if (req_fire) fetch_pc_nxt = fetch_pc + ADDR_W'(4);
    if (redirect_valid) begin
      fetch_pc_nxt = redir_target;
      state_nxt    = (drop_nxt != '0) ? DRAIN : FETCH;
`ifdef IFU_MISALIGN_TRAP_EN
      fault_nxt    = (redirect_pc[1:0] != 2'b00);
      if (redirect_pc[1:0] != 2'b00) state_nxt = HALT;
`endif
    end
  end

  // State, PC, counters and queue pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      inflight <= inflight_nxt;
      drop     <= drop_nxt;
      count    <= count_nxt;
      if (redirect_valid) begin
        resp_pc <= redir_target;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
      end else begin
        if (q_write) begin
          wr_ptr  <= wr_ptr + PW'(1);
          resp_pc <= resp_pc + ADDR_W'(4);
        end
        if (q_pop) rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Queue storage: instruction and its PC written side by side
  always_ff @(posedge clk) begin
    if (q_write) begin
      instr_mem[wr_ptr] <= imem_resp_data;
      pc_mem[wr_ptr]    <= resp_pc;
    end
  end

`ifdef IFU_MISALIGN_TRAP_EN
  // Sticky trap flag, cleared only by reset or an aligned redirect
  always_ff @(posedge clk) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_nxt;
  end
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

  // A live response into a full queue means the memory violated the credit contract
  overflow_chk: assert property (@(posedge clk) disable iff (rst)
    !(resp_live && !redirect_valid && q_full && !q_pop));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - randomized self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

  localparam int QDEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        fetch_fault;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .RESET_PC(32'h0000_0000),
    .QDEPTH  (QDEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .fetch_fault    (fetch_fault)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } mreq_t;

  mreq_t       mq[$];
  int          n_checks, n_fail;
  int          cyc, epoch, last_due, n_acc, n_dec;
  int          rq_pct, dr_pct, lat_lo, lat_hi;
  bit          redir_now, redir_on_coll, coll_hit, halted, prev_stall;
  logic [31:0] redir_tgt, exp_req, exp_dec, prev_pc, prev_instr;
  int          first_acc, first_dec, redir_cyc, first_acc_after;
  bit          have_dec_after;
  logic [31:0] dec_pc_after;
  bit          s_req_valid, s_dec_valid, s_fault;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req_valid", imem_req_valid, 0);
    check_eq("rst_dec_valid", dec_valid, 0);
    check_eq("rst_dec_instr", dec_instr, 0);
    check_eq("rst_dec_pc", dec_pc, 0);
    check_eq("rst_fault", fetch_fault, 0);
    rst = 1'b0;
    mq.delete();
    cyc = 0; epoch = 0; last_due = -1; n_acc = 0; n_dec = 0;
    exp_req = 32'h0; exp_dec = 32'h0; halted = 0; prev_stall = 0;
    first_acc = -1; first_dec = -1; redir_cyc = -1; first_acc_after = -1;
    have_dec_after = 0; redir_now = 0; redir_on_coll = 0; coll_hit = 0;
  endtask

  // One clock cycle: memory model drives, outputs are checked against the path model
  task automatic step();
    mreq_t       m;
    int          stale_n, lat, d;
    logic [31:0] tgt;
    @(negedge clk);
    stale_n = 0;
    foreach (mq[i]) if (mq[i].epoch != epoch) stale_n++;
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      m = mq.pop_front();
      imem_resp_valid = 1'b1;
      imem_resp_data  = instr_of(m.addr);
    end
    imem_req_ready = ($urandom_range(99) < rq_pct);
    dec_ready      = ($urandom_range(99) < dr_pct);
    redirect_valid = redir_now;
    redirect_pc    = redir_now ? redir_tgt : $urandom;
    redir_now      = 0;
    #1;
    if (redir_on_coll && dec_valid && dec_ready && imem_resp_valid) begin
      redirect_valid = 1'b1;
      redirect_pc    = redir_tgt;
      redir_on_coll  = 0;
      coll_hit       = 1;
    end
    s_req_valid = imem_req_valid;
    s_dec_valid = dec_valid;
    s_fault     = fetch_fault;
    check_eq("fault", fetch_fault, halted);
    if (halted) check_eq("halt_dec_valid", dec_valid, 0);
    if (prev_stall) begin
      check_eq("stall_valid", dec_valid, 1);
      check_eq("stall_pc", dec_pc, prev_pc);
      check_eq("stall_instr", dec_instr, prev_instr);
    end
    if (imem_req_valid && imem_req_ready) begin
      check_eq("req_addr", imem_req_addr, exp_req);
      check_eq("req_in_drain", stale_n + int'(halted), 0);
      check_eq("credit", (mq.size() + int'(imem_resp_valid)) < QDEPTH, 1);
      lat = $urandom_range(lat_hi, lat_lo);
      d = cyc + lat;
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      m.addr = imem_req_addr; m.due = d; m.epoch = epoch;
      mq.push_back(m);
      exp_req += 32'd4;
      n_acc++;
      if (first_acc < 0) first_acc = cyc;
      if (redir_cyc >= 0 && first_acc_after < 0) first_acc_after = cyc;
    end
    if (dec_valid && first_dec < 0) first_dec = cyc;
    if (dec_valid && dec_ready && !halted) begin
      check_eq("dec_pc", dec_pc, exp_dec);
      check_eq("dec_instr", dec_instr, instr_of(exp_dec));
      exp_dec += 32'd4;
      n_dec++;
      if (redir_cyc >= 0 && !have_dec_after) begin
        have_dec_after = 1;
        dec_pc_after   = dec_pc;
      end
    end
    prev_stall = dec_valid && !dec_ready && !redirect_valid;
    prev_pc    = dec_pc;
    prev_instr = dec_instr;
    if (redirect_valid) begin
      epoch++;
      tgt = redirect_pc;
`ifdef IFU_MISALIGN_TRAP_EN
      halted = (tgt[1:0] != 2'b00);
`endif
      tgt[1:0] = 2'b00;
      exp_req = tgt; exp_dec = tgt;
      redir_cyc = cyc; first_acc_after = -1; have_dec_after = 0;
    end
    cyc++;
  endtask

  task automatic set_mode(input int rq, input int dr, input int lo, input int hi);
    rq_pct = rq; dr_pct = dr; lat_lo = lo; lat_hi = hi;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t;
    int          k;
    n_checks = 0; n_fail = 0;
    set_mode(100, 100, 1, 1);

    // Straight-line fetch, first-instruction latency
    do_reset();
    step();
    check_eq("idle_no_req", s_req_valid, 0);
    repeat (20) step();
    check_eq("first_acc_cycle", first_acc, 1);
    check_eq("first_dec_latency", first_dec - first_acc, 2);
    check_eq("straight_decodes", n_dec > 5, 1);

    // Decode stalled: exactly QDEPTH requests, then resume in order
    do_reset();
    set_mode(100, 0, 1, 1);
    repeat (12) step();
    check_eq("stall_req_count", n_acc, QDEPTH);
    check_eq("stall_req_valid", s_req_valid, 0);
    set_mode(100, 100, 1, 1);
    repeat (10) step();
    check_eq("resume_decodes", n_dec >= 2, 1);

    // Redirect with two requests in flight, memory latency 3
    do_reset();
    set_mode(100, 100, 3, 3);
    k = 0;
    while (n_acc < 2 && k < 20) begin step(); k++; end
    check_eq("two_inflight", n_acc, 2);
    redir_tgt = 32'h100; redir_now = 1;
    repeat (20) step();
    check_eq("drain_first_req", first_acc_after - redir_cyc, 3);
    check_eq("drain_dec_pc", dec_pc_after, 32'h100);
    check_eq("drain_decodes", n_dec >= 2, 1);

    // Redirect coinciding with a response and a decode transfer
    do_reset();
    set_mode(100, 100, 1, 1);
    redir_tgt = 32'h40; redir_on_coll = 1;
    k = 0;
    while (!coll_hit && k < 30) begin step(); k++; end
    check_eq("collision_seen", coll_hit, 1);
    step();
    check_eq("collision_empty", s_dec_valid, 0);
    repeat (10) step();
    check_eq("collision_dec_pc", dec_pc_after, 32'h40);

    // Random traffic with random redirects, including near address wrap
    do_reset();
    set_mode(70, 70, 1, 4);
    k = 0;
    while (n_dec < 1000 && k < 30000) begin
      if (cyc > 1 && !redir_now && $urandom_range(99) < 2) begin
        t = $urandom;
        if ($urandom_range(3) == 0) t = 32'hFFFF_FFE0 | 32'($urandom_range(31));
`ifdef IFU_MISALIGN_TRAP_EN
        t[1:0] = 2'b00;
`endif
        redir_tgt = t; redir_now = 1;
      end
      step();
      k++;
    end
    check_eq("random_done", n_dec >= 1000, 1);

    // Misaligned redirect
    do_reset();
    set_mode(100, 100, 1, 1);
    repeat (6) step();
    redir_tgt = 32'h102; redir_now = 1;
    repeat (10) step();
`ifdef IFU_MISALIGN_TRAP_EN
    check_eq("trap_fault_set", s_fault, 1);
    check_eq("trap_no_req", s_req_valid, 0);
    redir_tgt = 32'h200; redir_now = 1;
    repeat (10) step();
    check_eq("trap_fault_clear", s_fault, 0);
    check_eq("trap_resume_pc", dec_pc_after, 32'h200);
`else
    check_eq("misalign_no_fault", s_fault, 0);
    check_eq("misalign_forced_pc", dec_pc_after, 32'h100);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
